// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM state encoding and default bus widths / NOP word.
// Optional error-response support is enabled by defining IF_FETCH_FAULT_EN.
package if_fetch_pkg;

  localparam int unsigned IF_ADDR_W = 32;
  localparam int unsigned IF_DATA_W = 32;

  // addi x0,x0,0 -- the canonical RISC-V NOP
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_skid.sv
// One-entry skid buffer holding a fetched word (data, address, optional fault) while decode stalls.
// Latency: a pushed entry is visible on the outputs the cycle after the push.
// Backpressure: the owner must not push while full; clr or rst empties it synchronously. Fault bit under IF_FETCH_FAULT_EN.
module if_skid_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clr,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_addr,
`ifdef IF_FETCH_FAULT_EN
  input  logic              push_fault,
  output logic              fault,
`endif
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] addr
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
`ifdef IF_FETCH_FAULT_EN
  logic              fault_q, fault_d;
`endif

  // Next-state: clear beats push beats pop; payload only loads on push
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    addr_d = addr_q;
`ifdef IF_FETCH_FAULT_EN
    fault_d = fault_q;
`endif
    if (rst || clr) begin
      full_d = 1'b0;
    end else if (push) begin
      full_d = 1'b1;
      data_d = push_data;
      addr_d = push_addr;
`ifdef IF_FETCH_FAULT_EN
      fault_d = push_fault;
`endif
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    full_q <= full_d;
    data_q <= data_d;
    addr_q <= addr_d;
`ifdef IF_FETCH_FAULT_EN
    fault_q <= fault_d;
`endif
  end

  assign full = full_q;
  assign data = data_q;
  assign addr = addr_q;
`ifdef IF_FETCH_FAULT_EN
  assign fault = fault_q;
`endif

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding req/gnt/rvalid transaction per PC, result registered into IF/ID.
// Latency: grant cycle, then rvalid (>=1 cycle later); inst_o updates the cycle after rvalid (max 1 inst / 2 cycles).
// Backpressure: hold_req_o freezes the PC until grant; a decode stall parks the word in a 1-entry skid. IF_FETCH_FAULT_EN adds error ports.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = IF_ADDR_W,
  parameter int                DATA_W   = IF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(INST_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_flag_i,
  input  logic              id_stall_i,
  output logic              hold_req_o,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_gnt_i,
  input  logic              ibus_rvalid_i,
  input  logic [DATA_W-1:0] ibus_rdata_i,
`ifdef IF_FETCH_FAULT_EN
  input  logic              ibus_err_i,
  output logic              inst_fault_o,
`endif
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic              inst_valid_q, inst_valid_d;

  logic              skid_full;
  logic [DATA_W-1:0] skid_data;
  logic [ADDR_W-1:0] skid_addr;
  logic              grant;
  logic              deliver;
  logic              skid_push;
  logic              skid_pop;
  logic [DATA_W-1:0] rsp_data;
`ifdef IF_FETCH_FAULT_EN
  logic              skid_fault;
  logic              inst_fault_q, inst_fault_d;
`endif

  // Request/handshake decode; a response is only meaningful while WAIT and no jump
  always_comb begin
    ibus_req_o = (state_q == FETCH_IDLE) && !rst && !jump_flag_i && !skid_full;
    grant      = ibus_req_o && ibus_gnt_i;
    hold_req_o = !grant;
    deliver    = (state_q == FETCH_WAIT) && ibus_rvalid_i && !jump_flag_i;
    skid_push  = deliver && id_stall_i;
    skid_pop   = skid_full && !id_stall_i;
`ifdef IF_FETCH_FAULT_EN
    rsp_data   = ibus_err_i ? NOP_INST : ibus_rdata_i;
`else
    rsp_data   = ibus_rdata_i;
`endif
  end

  assign ibus_addr_o = pc_i;

  // FSM next state and captured request address
  always_comb begin
    state_d    = state_q;
    req_addr_d = grant ? pc_i : req_addr_q;
    if (rst) begin
      state_d = FETCH_IDLE;
    end else begin
      unique case (state_q)
        FETCH_IDLE: if (grant) state_d = FETCH_WAIT;
        FETCH_WAIT: begin
          if (ibus_rvalid_i)    state_d = FETCH_IDLE;
          else if (jump_flag_i) state_d = FETCH_DROP;
        end
        FETCH_DROP: if (ibus_rvalid_i) state_d = FETCH_IDLE;
        default:    state_d = FETCH_IDLE;
      endcase
    end
  end

  // IF/ID register: flush > skid drain > fresh delivery > stall hold > bubble
  always_comb begin
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    inst_valid_d = inst_valid_q;
`ifdef IF_FETCH_FAULT_EN
    inst_fault_d = inst_fault_q;
`endif
    if (rst) begin
      inst_d       = NOP_INST;
      inst_addr_d  = '0;
      inst_valid_d = 1'b0;
`ifdef IF_FETCH_FAULT_EN
      inst_fault_d = 1'b0;
`endif
    end else if (jump_flag_i) begin
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
`ifdef IF_FETCH_FAULT_EN
      inst_fault_d = 1'b0;
`endif
    end else if (skid_pop) begin
      inst_d       = skid_data;
      inst_addr_d  = skid_addr;
      inst_valid_d = 1'b1;
`ifdef IF_FETCH_FAULT_EN
      inst_fault_d = skid_fault;
`endif
    end else if (deliver && !id_stall_i) begin
      inst_d       = rsp_data;
      inst_addr_d  = req_addr_q;
      inst_valid_d = 1'b1;
`ifdef IF_FETCH_FAULT_EN
      inst_fault_d = ibus_err_i;
`endif
    end else if (!id_stall_i) begin
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
`ifdef IF_FETCH_FAULT_EN
      inst_fault_d = 1'b0;
`endif
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    state_q      <= state_d;
    req_addr_q   <= req_addr_d;
    inst_q       <= inst_d;
    inst_addr_q  <= inst_addr_d;
    inst_valid_q <= inst_valid_d;
`ifdef IF_FETCH_FAULT_EN
    inst_fault_q <= inst_fault_d;
`endif
  end

  if_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (skid_push),
    .pop        (skid_pop),
    .clr        (jump_flag_i),
    .push_data  (rsp_data),
    .push_addr  (req_addr_q),
`ifdef IF_FETCH_FAULT_EN
    .push_fault (ibus_err_i),
    .fault      (skid_fault),
`endif
    .full       (skid_full),
    .data       (skid_data),
    .addr       (skid_addr)
  );

  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;
  assign inst_valid_o = inst_valid_q;
`ifdef IF_FETCH_FAULT_EN
  assign inst_fault_o = inst_fault_q;
`endif

endmodule
